// File: rtl/lwe_crypto_unit.sv
// Toy LWE arithmetic datapath: independent encrypt, homomorphic-add and decrypt lanes.
// All arithmetic wraps modulo a power-of-two modulus by truncation.
module lwe_crypto_unit #(
  parameter int unsigned PLAINTEXT_MODULUS  = 8,
  parameter int unsigned PLAINTEXT_WIDTH    = 3,
  parameter int unsigned CIPHERTEXT_MODULUS = 64,
  parameter int unsigned CIPHERTEXT_WIDTH   = 6,
  parameter int unsigned DIMENSION          = 1,
  parameter int unsigned BIG_N              = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PLAINTEXT_WIDTH-1:0]          enc_plaintext,
  input  logic [BIG_N*CIPHERTEXT_WIDTH-1:0]   enc_publickey_row,
  input  logic [BIG_N-1:0]                    enc_noise_select,
  input  logic [DIMENSION:0]                  enc_row,
  output logic [CIPHERTEXT_WIDTH-1:0]         enc_ciphertext,
  input  logic [CIPHERTEXT_WIDTH-1:0]         add_ciphertext1,
  input  logic [CIPHERTEXT_WIDTH-1:0]         add_ciphertext2,
  output logic [CIPHERTEXT_WIDTH-1:0]         add_result,
  input  logic                                dec_en,
  input  logic [CIPHERTEXT_WIDTH-1:0]         dec_secretkey_entry,
  input  logic [CIPHERTEXT_WIDTH-1:0]         dec_ciphertext_entry,
  input  logic [DIMENSION+1:0]                dec_row,
  output logic [PLAINTEXT_WIDTH-1:0]          dec_result
);

  localparam int unsigned CW = CIPHERTEXT_WIDTH;
  localparam int unsigned PW = PLAINTEXT_WIDTH;
  // Power-of-two moduli reduce to a low-bit mask.
  localparam logic [CW-1:0] QMask = CW'(CIPHERTEXT_MODULUS - 1);
  localparam logic [CW-1:0] PMask = CW'(PLAINTEXT_MODULUS - 1);

  logic [CW-1:0] enc_q, enc_d;
  logic [CW-1:0] add_q, add_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] noise_sum;
  logic [CW-1:0] term;

  always_comb begin
    noise_sum = '0;
    for (int i = 0; i < int'(BIG_N); i++) begin
      if (enc_noise_select[i]) begin
        noise_sum = noise_sum + enc_publickey_row[i*CW +: CW];
      end
    end
    noise_sum = noise_sum & QMask;

    // Only row 0 carries the message, added without scaling.
    if (enc_row == '0) begin
      enc_d = (noise_sum + {{(CW-PW){1'b0}}, enc_plaintext}) & QMask;
    end else begin
      enc_d = noise_sum;
    end

    add_d = (add_ciphertext1 + add_ciphertext2) & QMask;

    term  = (dec_secretkey_entry * dec_ciphertext_entry) & QMask;
    acc_d = acc_q;
    if (dec_en) begin
      // Row 0 always restarts the inner product, discarding any prior sum.
      acc_d = (dec_row == '0) ? term : ((acc_q + term) & QMask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_q <= '0;
      add_q <= '0;
      acc_q <= '0;
    end else begin
      enc_q <= enc_d;
      add_q <= add_d;
      acc_q <= acc_d;
    end
  end

  assign enc_ciphertext = enc_q;
  assign add_result     = add_q;
  assign dec_result     = PW'(acc_q & PMask);

endmodule

// File: tb/tb_lwe_crypto_unit.sv
// Bench for lwe_crypto_unit: vector table, reset sequences and a random scoreboard phase.
module tb_lwe_crypto_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  enc_plaintext;
  logic [29:0] enc_publickey_row;
  logic [4:0]  enc_noise_select;
  logic [1:0]  enc_row;
  logic [5:0]  enc_ciphertext;
  logic [5:0]  add_ciphertext1, add_ciphertext2, add_result;
  logic        dec_en;
  logic [5:0]  dec_secretkey_entry, dec_ciphertext_entry;
  logic [2:0]  dec_row;
  logic [2:0]  dec_result;

  always #5 clk = ~clk;

  lwe_crypto_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .enc_plaintext        (enc_plaintext),
    .enc_publickey_row    (enc_publickey_row),
    .enc_noise_select     (enc_noise_select),
    .enc_row              (enc_row),
    .enc_ciphertext       (enc_ciphertext),
    .add_ciphertext1      (add_ciphertext1),
    .add_ciphertext2      (add_ciphertext2),
    .add_result           (add_result),
    .dec_en               (dec_en),
    .dec_secretkey_entry  (dec_secretkey_entry),
    .dec_ciphertext_entry (dec_ciphertext_entry),
    .dec_row              (dec_row),
    .dec_result           (dec_result)
  );

  typedef struct {
    logic [2:0]  m;
    logic [29:0] pk;
    logic [4:0]  sel;
    logic [1:0]  row;
    logic [5:0]  a, b;
    logic        den;
    logic [5:0]  sk, ct;
    logic [2:0]  drow;
    logic [5:0]  exp_enc, exp_add;
    logic [2:0]  exp_dec;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [5:0] q_enc[$];
  logic [5:0] q_add[$];
  logic [2:0] q_dec[$];
  vec_t vecs[9];
  logic [29:0] pk_a, pk_b;
  int model_acc;

  function automatic logic [29:0] pack(input int e0, e1, e2, e3, e4);
    return {6'(e4), 6'(e3), 6'(e2), 6'(e1), 6'(e0)};
  endfunction

  function automatic vec_t mk(input int m, input logic [29:0] pk, input logic [4:0] sel,
                              input int row, a, b, den, sk, ct, drow, ee, ea, ed);
    vec_t v;
    v.m = 3'(m); v.pk = pk; v.sel = sel; v.row = 2'(row);
    v.a = 6'(a); v.b = 6'(b); v.den = den[0]; v.sk = 6'(sk); v.ct = 6'(ct);
    v.drow = 3'(drow); v.exp_enc = 6'(ee); v.exp_add = 6'(ea); v.exp_dec = 3'(ed);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    enc_plaintext = v.m; enc_publickey_row = v.pk; enc_noise_select = v.sel; enc_row = v.row;
    add_ciphertext1 = v.a; add_ciphertext2 = v.b;
    dec_en = v.den; dec_secretkey_entry = v.sk; dec_ciphertext_entry = v.ct; dec_row = v.drow;
  endtask

  // Drive one cycle of stimulus, then compare against the scoreboard after the edge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    q_enc.push_back(v.exp_enc);
    q_add.push_back(v.exp_add);
    q_dec.push_back(v.exp_dec);
    @(posedge clk);
    #1;
    check({tag, "_enc"}, 32'(enc_ciphertext), 32'(q_enc.pop_front()));
    check({tag, "_add"}, 32'(add_result), 32'(q_add.pop_front()));
    check({tag, "_dec"}, 32'(dec_result), 32'(q_dec.pop_front()));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_enc"}, 32'(enc_ciphertext), 32'd0);
    check({tag, "_add"}, 32'(add_result), 32'd0);
    check({tag, "_dec"}, 32'(dec_result), 32'd0);
  endtask

  function automatic vec_t rand_vec(input bit force_start);
    vec_t v;
    int s;
    longint p;
    v.m = 3'($urandom); v.pk = 30'($urandom); v.sel = 5'($urandom); v.row = 2'($urandom);
    v.a = 6'($urandom); v.b = 6'($urandom);
    v.den = force_start ? 1'b1 : ($urandom_range(0, 3) != 0);
    v.sk = 6'($urandom); v.ct = 6'($urandom);
    v.drow = force_start ? 3'd0 : (($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7)));
    s = 0;
    for (int i = 0; i < 5; i++) if (v.sel[i]) s += int'(v.pk[i*6 +: 6]);
    if (v.row == 2'd0) s += int'(v.m);
    v.exp_enc = 6'(s % 64);
    v.exp_add = 6'((int'(v.a) + int'(v.b)) % 64);
    p = longint'(v.sk) * longint'(v.ct);
    if (v.den) model_acc = (v.drow == 3'd0) ? int'(p % 64) : int'((model_acc + p) % 64);
    v.exp_dec = 3'(model_acc % 8);
    return v;
  endfunction

  initial begin
    pk_a = pack(36, 20, 60, 12, 36);
    pk_b = pack(61, 25, 1, 11, 13);
    vecs[0] = mk(2, pk_a, 5'b10111, 0, 26, 5,  1, 1, 38, 0,  26, 31, 6);
    vecs[1] = mk(1, pk_a, 5'b11010, 0, 36, 49, 1, 20, 62, 1, 5,  21, 6);
    vecs[2] = mk(0, pk_b, 5'b11010, 1, 63, 1,  1, 16, 52, 2, 49, 0,  6);
    vecs[3] = mk(2, pk_b, 5'b10111, 1, 40, 30, 0, 7, 7, 1,   36, 6,  6);
    vecs[4] = mk(7, pk_a, 5'b00000, 0, 63, 63, 0, 7, 7, 1,   7,  62, 6);
    vecs[5] = mk(5, pk_b, 5'b11111, 3, 1, 2,   0, 7, 7, 2,   47, 3,  6);
    vecs[6] = mk(3, pk_a, 5'b00001, 2, 0, 0,   1, 1, 5, 0,   36, 0,  5);
    vecs[7] = mk(4, pk_b, 5'b00100, 0, 17, 17, 1, 3, 3, 0,   5,  34, 1);
    vecs[8] = mk(0, pk_b, 5'b01000, 1, 32, 32, 1, 2, 2, 0,   11, 0,  4);

    rst = 1'b0;
    drive(mk(5, pk_b, 5'b11111, 0, 50, 60, 1, 9, 9, 0, 0, 0, 0));
    #1 rst = 1'b1;
    #1 check_zero("reset_async");
    repeat (3) begin
      @(negedge clk);
      drive(rand_vec(1'b0));
    end
    #1 check_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Partial accumulation, then an asynchronous reset between edges.
    apply(mk(0, pk_a, 5'b00001, 1, 10, 20, 1, 1, 3, 0, 36, 30, 3), "part0");
    apply(mk(0, pk_a, 5'b00001, 1, 10, 20, 1, 1, 2, 1, 36, 30, 5), "part1");
    rst = 1'b1;
    #1 check_zero("reset_mid");
    #2 rst = 1'b0;
    apply(vecs[0], "post_rst0");
    apply(vecs[1], "post_rst1");
    apply(vecs[2], "post_rst2");

    model_acc = 0;
    apply(rand_vec(1'b1), "rnd_start");
    for (int i = 0; i < 60; i++) apply(rand_vec(1'b0), $sformatf("rnd%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
